// File: rtl/tm_inference_ctrl.sv
// tm_inference_ctrl
//   Sequencer for the Tsetlin Machine inference datapath. Loads N_CLAUSE
//   literal masks from a word-serial config stream, then runs one feature
//   sample at a time through the datapath and returns the captured class
//   over a valid/ready result port. Only one inference is in flight.
//
// Ports
//   clk1, rst1            clock (rising edge), async active-high reset
//   cfg_valid/ready/data  config word stream, clause 0 first
//   cfg_restart           1-cycle pulse: discard the model and reload
//   cfg_done              all clause masks loaded
//   s_valid/ready/features  sample input handshake
//   dp_features, dp_ex    to the inference core (clause k at [k*LIT_W +: LIT_W])
//   dp_class              class from the inference core
//   m_valid/ready/class   result output handshake
//   sample_count          results delivered, saturating (TM_SAMPLE_COUNT_EN only)
//
// Build option
//   TM_SAMPLE_COUNT_EN    adds the sample_count output and its counter.
//
// All outputs are registered or decoded from the registered state.

module tm_inference_ctrl #(
  parameter int N_FEAT   = 9,
  parameter int N_CLAUSE = 12,
  parameter int LIT_W    = 18,
  parameter int CLASS_W  = 2,
  parameter int INF_LAT  = 1
) (
  input  logic                      clk1,
  input  logic                      rst1,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [LIT_W-1:0]          cfg_data,
  input  logic                      cfg_restart,
  output logic                      cfg_done,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [N_FEAT-1:0]         s_features,
  output logic [N_FEAT-1:0]         dp_features,
  output logic [N_CLAUSE*LIT_W-1:0] dp_ex,
  input  logic [CLASS_W-1:0]        dp_class,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [CLASS_W-1:0]        m_class
`ifdef TM_SAMPLE_COUNT_EN
  ,
  output logic [15:0]               sample_count
`endif
);

  localparam int IDX_W = (N_CLAUSE > 1) ? $clog2(N_CLAUSE) : 1;
  localparam int CNT_W = $clog2(INF_LAT + 1);

  localparam logic [1:0] S_CFG  = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             restart_pend;
  logic             restart_now;

  assign cfg_ready = (state == S_CFG);
  assign s_ready   = (state == S_IDLE);

  // A restart takes effect immediately in CFG/IDLE; in RUN/HOLD it waits
  // until the in-flight result has completed its handshake.
  always_comb begin
    restart_now = 1'b0;
    case (state)
      S_CFG, S_IDLE: restart_now = cfg_restart;
      S_HOLD:        restart_now = m_ready && (restart_pend || cfg_restart);
      default:       restart_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      state        <= S_CFG;
      idx          <= '0;
      cnt          <= '0;
      restart_pend <= 1'b0;
      cfg_done     <= 1'b0;
      dp_ex        <= '0;
      dp_features  <= '0;
      m_class      <= '0;
      m_valid      <= 1'b0;
    end else if (restart_now) begin
      state        <= S_CFG;
      idx          <= '0;
      restart_pend <= 1'b0;
      cfg_done     <= 1'b0;
      dp_ex        <= '0;
      m_valid      <= 1'b0;
    end else begin
      case (state)
        S_CFG: begin
          if (cfg_valid) begin
            dp_ex[idx*LIT_W +: LIT_W] <= cfg_data;
            if (idx == IDX_W'(N_CLAUSE - 1)) begin
              idx      <= '0;
              cfg_done <= 1'b1;
              state    <= S_IDLE;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        S_IDLE: begin
          if (s_valid) begin
            dp_features <= s_features;
            cnt         <= CNT_W'(INF_LAT);
            state       <= S_RUN;
          end
        end
        S_RUN: begin
          if (cfg_restart) restart_pend <= 1'b1;
          // Count reaches zero INF_LAT edges after the accept; one further
          // edge lets the registered dp_features settle through the
          // datapath before dp_class is sampled.
          if (cnt == '0) begin
            m_class <= dp_class;
            m_valid <= 1'b1;
            state   <= S_HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cfg_restart) restart_pend <= 1'b1;
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_CFG;
      endcase
    end
  end

`ifdef TM_SAMPLE_COUNT_EN
  always_ff @(posedge clk1 or posedge rst1) begin
    if (rst1) begin
      sample_count <= '0;
    end else if (restart_now) begin
      sample_count <= '0;
    end else if (m_valid && m_ready && (sample_count != 16'hFFFF)) begin
      sample_count <= sample_count + 16'd1;
    end
  end
`endif

endmodule
